// File: rtl/pattern_gen_param.sv
`default_nettype none
// ============================================================================
// Module   : pattern_gen_param
// Brief    : Parametrised frame test-pattern generator driven by raw
//            fval/lval/dval timing. Optional macro PATTERN_GEN_SCROLL_EN
//            makes the checker scroll by SCROLL_STEP pixels per frame.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_gen_param #(
    parameter int PIX_W       = 8,
    parameter int H_ACT       = 640,
    parameter int V_ACT       = 480,
    parameter int GRAD_STEP   = 1,
    parameter int CHK_LOG2    = 5,
    parameter int SCROLL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       sel,
    input  logic             fval,
    input  logic             lval,
    input  logic             dval,
    output logic [PIX_W-1:0] pix_value,
    output logic             pix_valid,
    output logic [15:0]      frame_cnt,
    output logic             overrun
);

    localparam int c_XW  = $clog2(H_ACT + 1);
    localparam int c_YW  = $clog2(V_ACT + 1);
    localparam int c_HPW = c_XW + 32;
    localparam int c_VPW = c_YW + 32;
    localparam longint unsigned c_MAXV_L = (64'd1 << PIX_W) - 64'd1;
    localparam logic [PIX_W-1:0] c_MAXV  = '1;
`ifdef PATTERN_GEN_SCROLL_EN
    localparam int c_XSW = 16;
`else
    localparam int c_XSW = c_XW;
`endif
    localparam logic [c_XSW-1:0] c_XMASK = c_XSW'(1) << CHK_LOG2;
    localparam logic [c_YW-1:0]  c_YMASK = c_YW'(1) << CHK_LOG2;

    logic             r_fval_d, r_lval_d;
    logic [c_XW-1:0]  r_x;
    logic [c_YW-1:0]  r_y;
    logic [2:0]       r_mode;
    logic [15:0]      r_frame_cnt;
    logic             r_overrun;
    logic [PIX_W-1:0] r_pix_value;
    logic             r_pix_valid;

    logic             w_fval_rise, w_lval_fall, w_oob;
    logic [c_XW-1:0]  w_x_cur, w_x_nxt;
    logic [c_YW-1:0]  w_y_cur;
    logic [2:0]       w_mode_cur;
    logic [15:0]      w_fcnt_cur;
    logic [c_XSW-1:0] w_xs;
    logic [c_HPW-1:0] w_hprod;
    logic [c_VPW-1:0] w_vprod;
    logic             w_chk, w_border;
    logic [PIX_W-1:0] w_bar_val, w_pix;

    assign w_fval_rise = fval & ~r_fval_d;
    assign w_lval_fall = ~lval & r_lval_d;

    // Coordinates/mode that apply to a dval sampled this cycle
    always_comb begin
        w_x_cur    = r_x;
        w_y_cur    = r_y;
        w_mode_cur = r_mode;
        w_fcnt_cur = r_frame_cnt;
        if (w_fval_rise) begin
            w_x_cur    = '0;
            w_y_cur    = '0;
            w_mode_cur = sel;
            w_fcnt_cur = r_frame_cnt + 16'd1;
        end else if (w_lval_fall) begin
            w_x_cur = '0;
            w_y_cur = (r_y == c_YW'(V_ACT)) ? r_y : r_y + 1'b1;
        end
    end

    assign w_oob   = (w_x_cur >= c_XW'(H_ACT)) || (w_y_cur >= c_YW'(V_ACT));
    assign w_x_nxt = (dval && (w_x_cur != c_XW'(H_ACT))) ? w_x_cur + 1'b1 : w_x_cur;

`ifdef PATTERN_GEN_SCROLL_EN
    // r_scroll_acc counts ahead; r_scroll_off is the offset frozen for the current frame
    logic [15:0] r_scroll_acc, r_scroll_off;
    logic [15:0] w_scroll_cur;

    assign w_scroll_cur = w_fval_rise ? r_scroll_acc : r_scroll_off;
    assign w_xs         = 16'(w_x_cur) + w_scroll_cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scroll_acc <= '0;
            r_scroll_off <= '0;
        end else if (w_fval_rise) begin
            r_scroll_acc <= r_scroll_acc + 16'(SCROLL_STEP);
            r_scroll_off <= r_scroll_acc;
        end
    end
`else
    logic w_unused_scroll;
    assign w_unused_scroll = (SCROLL_STEP != 0);
    assign w_xs            = w_x_cur;
`endif

    assign w_chk   = (|(w_xs & c_XMASK)) ^ (|(w_y_cur & c_YMASK));
    assign w_hprod = c_HPW'(w_x_cur) * c_HPW'(GRAD_STEP);
    assign w_vprod = c_VPW'(w_y_cur) * c_VPW'(GRAD_STEP);

    assign w_border = (w_x_cur == '0) || (w_x_cur == c_XW'(H_ACT - 1)) ||
                      (w_y_cur == '0) || (w_y_cur == c_YW'(V_ACT - 1)) ||
                      (w_x_cur == c_XW'(H_ACT / 2)) || (w_y_cur == c_YW'(V_ACT / 2));

    // Bar edges and levels unroll to constants
    always_comb begin
        w_bar_val = '0;
        for (int k = 1; k < 8; k++) begin
            if (32'(w_x_cur) >= 32'((H_ACT * k) / 8))
                w_bar_val = PIX_W'((c_MAXV_L * 64'(k)) / 64'd7);
        end
    end

    always_comb begin
        w_pix = '0;
        case (w_mode_cur)
            3'b000: w_pix = '0;
            3'b001: w_pix = c_MAXV;
            3'b010: w_pix = (w_hprod > c_HPW'(c_MAXV_L)) ? c_MAXV : PIX_W'(w_hprod);
            3'b011: w_pix = w_chk ? c_MAXV : '0;
            3'b100: w_pix = (w_vprod > c_VPW'(c_MAXV_L)) ? c_MAXV : PIX_W'(w_vprod);
            3'b101: w_pix = w_bar_val;
            3'b110: w_pix = PIX_W'(w_fcnt_cur);
            default: w_pix = w_border ? c_MAXV : '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fval_d    <= 1'b0;
            r_lval_d    <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_mode      <= 3'b000;
            r_frame_cnt <= '0;
            r_overrun   <= 1'b0;
            r_pix_value <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r_fval_d    <= fval;
            r_lval_d    <= lval;
            r_x         <= w_x_nxt;
            r_y         <= w_y_cur;
            r_mode      <= w_mode_cur;
            r_frame_cnt <= w_fcnt_cur;
            r_overrun   <= (r_overrun & ~w_fval_rise) | (dval & w_oob);
            r_pix_valid <= dval;
            r_pix_value <= (dval && !w_oob) ? w_pix : '0;
        end
    end

    assign pix_value = r_pix_value;
    assign pix_valid = r_pix_valid;
    assign frame_cnt = r_frame_cnt;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire
